// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, defaults and helpers for the clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SHOT = 2'd2
    } state_t;

    localparam int unsigned DEF_DIV = 50_000_000;

    // A zero divisor has no meaning; treat it as "tick every cycle".
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/period_counter.sv
// rtl/period_counter.sv - wrapping period counter with clear/enable and terminal count
module period_counter #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable tick scheduler with free-run and single-shot modes
module clk_div_ctrl #(
    parameter int          CNT_W   = 26,
    parameter int unsigned DEF_DIV = clk_div_pkg::DEF_DIV,
    parameter int          TCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_shot,
    input  logic              start,
    input  logic              stop,
    output logic              tick,
    output logic              sq_out,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_cnt
);

    import clk_div_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   div_r;
    logic               shot_r;
    logic [CNT_W-1:0]   pend_div;
    logic               pend_shot;
    logic               pend;
    logic               tc;
    logic               accept;
    logic               launch;
    logic [CNT_W-1:0]   cfg_div_c;
    logic [CNT_W-1:0]   div_last;

    assign busy      = (state != IDLE);
    assign cfg_ready = !busy || !pend;
    assign accept    = cfg_valid && cfg_ready;
    assign launch    = !busy && start && !stop;
    assign cfg_div_c = CNT_W'(clamp_div(32'(cfg_div)));
    assign div_last  = div_r - CNT_W'(1);

    // A stop in the terminal cycle wins, so the tick is masked rather than delayed.
    assign tick = busy && tc && !stop;

    period_counter #(
        .W (CNT_W)
    ) u_period_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy || stop),
        .en    (busy),
        .last  (div_last),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_r     <= CNT_W'(DEF_DIV);
            shot_r    <= 1'b0;
            pend_div  <= '0;
            pend_shot <= 1'b0;
            pend      <= 1'b0;
            sq_out    <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            if (tick) begin
                sq_out   <= ~sq_out;
                tick_cnt <= tick_cnt + TCNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_r  <= cfg_div_c;
                        shot_r <= cfg_shot;
                    end
                    if (launch) begin
                        state    <= (accept ? cfg_shot : shot_r) ? SHOT : RUN;
                        tick_cnt <= '0;
                    end
                end
                RUN, SHOT: begin
                    if (stop) begin
                        state <= IDLE;
                        pend  <= 1'b0;
                    end else begin
                        // Pending config only lands on a period boundary.
                        if (tick) begin
                            if (pend) begin
                                div_r  <= pend_div;
                                shot_r <= pend_shot;
                                pend   <= 1'b0;
                            end
                            if (state == SHOT) begin
                                state <= IDLE;
                            end
                        end
                        if (accept) begin
                            pend_div  <= cfg_div_c;
                            pend_shot <= cfg_shot;
                            pend      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - table-driven and directed checks for clk_div_ctrl
module tb_clk_div_ctrl;

    localparam int CNT_W  = 26;
    localparam int TCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_shot;
    logic              start;
    logic              stop;
    logic              tick;
    logic              sq_out;
    logic              busy;
    logic [TCNT_W-1:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (4),
        .TCNT_W  (TCNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_shot  (cfg_shot),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .sq_out    (sq_out),
        .busy      (busy),
        .tick_cnt  (tick_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       cv;
        int         cd;
        logic       cs;
        logic       e_tick;
        logic       e_busy;
        logic       e_sq;
        logic       e_rdy;
        int         e_tcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic sp, input logic cv, input int cd,
                                input logic cs, input logic e_tick, input logic e_busy,
                                input logic e_sq, input logic e_rdy, input int e_tcnt);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.cd = cd; v.cs = cs;
        v.e_tick = e_tick; v.e_busy = e_busy; v.e_sq = e_sq; v.e_rdy = e_rdy; v.e_tcnt = e_tcnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic sp, input logic cv, input int cd, input logic cs);
        start     = st;
        stop      = sp;
        cfg_valid = cv;
        cfg_div   = CNT_W'(cd);
        cfg_shot  = cs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // free-run at the reset divisor of 4: ticks at cycles 4, 8, 12, then stop
        add(1,0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0,0, 0,1,0,1,0);
        add(0,0,0,0,0, 0,1,0,1,0);
        add(0,0,0,0,0, 0,1,0,1,0);
        add(0,0,0,0,0, 1,1,0,1,0);
        add(0,0,0,0,0, 0,1,1,1,1);
        add(0,0,0,0,0, 0,1,1,1,1);
        add(0,0,0,0,0, 0,1,1,1,1);
        add(0,0,0,0,0, 1,1,1,1,1);
        add(0,0,0,0,0, 0,1,0,1,2);
        add(0,0,0,0,0, 0,1,0,1,2);
        add(0,0,0,0,0, 0,1,0,1,2);
        add(0,0,0,0,0, 1,1,0,1,2);
        add(0,1,0,0,0, 0,1,1,1,3);
        add(0,0,0,0,0, 0,0,1,1,3);
        // N=5 configured with start; N=3 accepted at cycle 2 lands after tick at 5
        add(1,0,1,5,0, 0,0,1,1,3);
        add(0,0,0,0,0, 0,1,1,1,0);
        add(0,0,1,3,0, 0,1,1,1,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0,0, 0,1,1,0,0);
        add(0,0,0,0,0, 1,1,1,0,0);
        add(0,0,0,0,0, 0,1,0,1,1);
        add(0,0,0,0,0, 0,1,0,1,1);
        add(0,0,0,0,0, 1,1,0,1,1);
        add(0,0,0,0,0, 0,1,1,1,2);
        add(0,0,0,0,0, 0,1,1,1,2);
        add(0,0,0,0,0, 1,1,1,1,2);
        add(0,1,0,0,0, 0,1,0,1,3);
        add(0,0,0,0,0, 0,0,0,1,3);

        rst_n = 1'b0;
        set_in(0,0,0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sq", sq_out, 0);
        chk("rst_tcnt", tick_cnt, 0);
        chk("rst_rdy", cfg_ready, 1);
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_in(vecs[i].st, vecs[i].sp, vecs[i].cv, vecs[i].cd, vecs[i].cs);
            @(negedge clk);
            chk($sformatf("row%0d_tick", i), tick, vecs[i].e_tick);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("row%0d_sq", i), sq_out, vecs[i].e_sq);
            chk($sformatf("row%0d_rdy", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("row%0d_tcnt", i), tick_cnt, vecs[i].e_tcnt);
            step();
        end
        set_in(0,0,0,0,0);

        // single shot, N=6
        set_in(1,0,1,6,1);
        @(negedge clk);
        chk("shot_rdy", cfg_ready, 1);
        step();
        set_in(0,0,0,0,0);
        n = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (tick) n++;
            step();
        end
        chk("shot_early", n, 0);
        @(negedge clk);
        chk("shot_tick", tick, 1);
        step();
        @(negedge clk);
        chk("shot_busy_drop", busy, 0);
        chk("shot_sq", sq_out, 1);
        chk("shot_tcnt", tick_cnt, 1);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (tick || busy) n++;
            step();
        end
        chk("shot_quiet", n, 0);

        // stop coinciding with the tick, then start+stop in idle
        set_in(1,0,1,4,0);
        step();
        set_in(0,0,0,0,0);
        repeat (3) step();
        stop = 1'b1;
        @(negedge clk);
        chk("stop_tick", tick, 0);
        step();
        stop = 1'b0;
        @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_sq", sq_out, 1);
        chk("stop_tcnt", tick_cnt, 0);
        set_in(1,1,0,0,0);
        @(negedge clk);
        chk("ss_tick", tick, 0);
        step();
        set_in(0,0,0,0,0);
        @(negedge clk);
        chk("ss_busy", busy, 0);
        chk("ss_sq", sq_out, 1);

        // cfg_div=0 clamps to 1: tick every busy cycle, tick_cnt wraps
        set_in(1,0,1,0,0);
        step();
        set_in(0,0,0,0,0);
        n = 0;
        for (int c = 1; c <= 65535; c++) begin
            @(negedge clk);
            if (!tick) n++;
            step();
        end
        chk("div0_every_cycle", n, 0);
        @(negedge clk);
        chk("wrap_ffff", tick_cnt, 16'hFFFF);
        step();
        @(negedge clk);
        chk("wrap_zero", tick_cnt, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // async reset with a pending config, then default divisor after release
        set_in(1,0,1,7,0);
        step();
        set_in(0,0,0,0,0);
        step();
        set_in(0,0,1,3,0);
        @(negedge clk);
        chk("pend_accept_rdy", cfg_ready, 1);
        step();
        set_in(0,0,0,0,0);
        @(negedge clk);
        chk("pend_rdy_low", cfg_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sq", sq_out, 0);
        chk("arst_tcnt", tick_cnt, 0);
        chk("arst_rdy", cfg_ready, 1);
        step();
        rst_n = 1'b1;
        set_in(1,0,0,0,0);
        step();
        set_in(0,0,0,0,0);
        n = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (tick) n++;
            step();
        end
        chk("post_rst_early", n, 0);
        @(negedge clk);
        chk("post_rst_tick4", tick, 1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
